fetch_line_responder: RTL and testbench

//  Responder side of the fetch-address interface: consumes the fetch stage's fetchpc each cycle
//  and returns the instruction word for that PC one cycle later, aligned with the fetch stage's

---
 rtl/fetch_line_responder.sv | 95 +++++++++
 tb/tb_fetch_line_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_responder.sv
// Single-line instruction buffer answering fetchpc one cycle later; misses stall fetch
// and refill the whole line from backing memory, beat 0 first, over a req/ack handshake.
module fetch_line_responder #(
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetchpc,
  input  logic        inval,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        stall_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam int TAG_W  = 32 - OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state;
  logic                req_valid;
  logic                line_valid;
  logic [TAG_W-1:0]    tag;
  logic [BEAT_W-1:0]   beat;
  logic [31:0]         line [LINE_WORDS];
  logic                hit;
  logic                in_fill;

  assign in_fill     = (state == FILL);
  assign hit         = req_valid & line_valid & (instr_pc[31:OFF_W] == tag);
  // Registers only: keeps fetchpc out of the fetch stage's stall mux loop.
  assign stall_out   = (req_valid & ~hit) | in_fill;
  assign instr_valid = hit & ~in_fill;
  assign instr       = instr_valid ? line[instr_pc[OFF_W-1:2]] : 32'h0;
  assign mem_req     = in_fill;
  assign mem_addr    = in_fill ? {tag, beat, 2'b00} : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_valid  <= 1'b0;
      line_valid <= 1'b0;
      beat       <= '0;
      tag        <= '0;
      instr_pc   <= 32'h0;
    end else begin
      if (!stall_out) begin
        instr_pc  <= fetchpc;
        req_valid <= 1'b1;
      end
      // Invalidate wins over everything, including an ack arriving the same cycle.
      if (inval) begin
        line_valid <= 1'b0;
        state      <= IDLE;
        beat       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid && !hit) begin
              state      <= FILL;
              beat       <= '0;
              tag        <= instr_pc[31:OFF_W];
              line_valid <= 1'b0;
            end
          end
          FILL: begin
            if (mem_ack) begin
              beat <= beat + 1'b1;
              if (beat == BEAT_W'(LINE_WORDS - 1)) begin
                line_valid <= 1'b1;
                beat       <= '0;
                state      <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Line storage is pure data: no reset, written only by accepted fill beats.
  always_ff @(posedge clk) begin
    if (in_fill && mem_ack && !inval) begin
      line[beat] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_line_responder.sv
// Directed bench for fetch_line_responder: drives and samples on the falling edge and
// plays the backing memory, whose word at address a is a ^ 32'h5A5A0000.
module tb_fetch_line_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetchpc;
  logic        inval;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        stall_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  fetch_line_responder #(.LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .fetchpc(fetchpc), .inval(inval),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .stall_out(stall_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction

  // Answers one line fill; acks when (cycle % period) == period-1 while mem_req is high.
  task automatic serve_fill(input logic [31:0] base, input int period, input logic [31:0] held_pc);
    int k = 0;
    int cyc = 0;
    while (k < 8 && cyc < 200) begin
      if (mem_req) begin
        total++;
        if (mem_addr !== base + 32'(4 * k)) begin
          bad++;
          $display("FAIL fill_addr base=%h beat=%0d got=%h exp=%h", base, k, mem_addr, base + 32'(4 * k));
        end
        total++;
        if (instr_pc !== held_pc) begin
          bad++;
          $display("FAIL fill_hold_pc got=%h exp=%h", instr_pc, held_pc);
        end
        if ((cyc % period) == period - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          k++;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    total++;
    if (k < 8) begin
      bad++;
      $display("FAIL fill_timeout base=%h beats=%0d exp=8", base, k);
    end
  endtask

  task automatic check_hit(input string name, input logic [31:0] pc);
    total++;
    if (instr_valid !== 1'b1 || stall_out !== 1'b0 || instr_pc !== pc || instr !== mem_word(pc) || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL %s got v=%b st=%b pc=%h ins=%h req=%b exp v=1 st=0 pc=%h ins=%h req=0",
               name, instr_valid, stall_out, instr_pc, instr, mem_req, pc, mem_word(pc));
    end
  endtask

  task automatic check_miss(input string name, input logic [31:0] pc);
    total++;
    if (instr_valid !== 1'b0 || stall_out !== 1'b1 || instr_pc !== pc) begin
      bad++;
      $display("FAIL %s got v=%b st=%b pc=%h exp v=0 st=1 pc=%h", name, instr_valid, stall_out, instr_pc, pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fetchpc = 32'h0; inval = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || stall_out !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 ||
        instr !== 32'h0 || instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_state got v=%b st=%b req=%b addr=%h ins=%h pc=%h exp all zero",
               instr_valid, stall_out, mem_req, mem_addr, instr, instr_pc);
    end
  endtask

  task automatic test_cold_start();
    rst = 1'b0; fetchpc = 32'h0;
    @(negedge clk);
    check_miss("cold_stall", 32'h0);
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL cold_req_early got=%b exp=0", mem_req);
    end
    serve_fill(32'h0, 1, 32'h0);
    check_hit("cold_first_hit", 32'h0);
  endtask

  task automatic test_sequential_hits();
    for (int i = 1; i <= 3; i++) begin
      fetchpc = 32'(4 * i);
      @(negedge clk);
      check_hit("seq_hit", 32'(4 * i));
    end
  endtask

  task automatic test_line_crossing();
    fetchpc = 32'h1C;
    @(negedge clk);
    check_hit("cross_last_word", 32'h1C);
    fetchpc = 32'h20;
    @(negedge clk);
    check_miss("cross_stall", 32'h20);
    serve_fill(32'h20, 1, 32'h20);
    check_hit("cross_new_line", 32'h20);
  endtask

  task automatic test_slow_memory();
    fetchpc = 32'h40;
    @(negedge clk);
    check_miss("slow_stall", 32'h40);
    serve_fill(32'h40, 3, 32'h40);
    check_hit("slow_first", 32'h40);
    for (int i = 1; i < 8; i++) begin
      fetchpc = 32'h40 + 32'(4 * i);
      @(negedge clk);
      check_hit("slow_contents", 32'h40 + 32'(4 * i));
    end
  endtask

  task automatic test_inval_fill();
    int w = 0;
    fetchpc = 32'h60;
    @(negedge clk);
    check_miss("inval_stall", 32'h60);
    while (!mem_req && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h60 + 32'(4 * k)) begin
        bad++;
        $display("FAIL inval_pre_addr got req=%b addr=%h exp req=1 addr=%h", mem_req, mem_addr, 32'h60 + 32'(4 * k));
      end
      mem_ack   = 1'b1;
      mem_rdata = (k == 3) ? 32'hDEADBEEF : mem_word(mem_addr);
      inval     = (k == 3);
      @(negedge clk);
    end
    mem_ack = 1'b0; inval = 1'b0;
    total++;
    if (mem_req !== 1'b0 || stall_out !== 1'b1) begin
      bad++;
      $display("FAIL inval_drop got req=%b st=%b exp req=0 st=1", mem_req, stall_out);
    end
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h60) begin
      bad++;
      $display("FAIL inval_restart got req=%b addr=%h exp req=1 addr=00000060", mem_req, mem_addr);
    end
    serve_fill(32'h60, 1, 32'h60);
    check_hit("inval_refill_first", 32'h60);
    fetchpc = 32'h6C;
    @(negedge clk);
    check_hit("inval_refill_beat3", 32'h6C);
  endtask

  task automatic test_inval_idle();
    fetchpc = 32'h64; inval = 1'b1;
    @(negedge clk);
    inval = 1'b0;
    check_miss("inval_idle_miss", 32'h64);
    serve_fill(32'h60, 1, 32'h64);
    check_hit("inval_idle_refill", 32'h64);
  endtask

  task automatic test_reset_mid_fill();
    fetchpc = 32'h80;
    @(negedge clk);
    check_miss("rstfill_stall", 32'h80);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1'b1; mem_rdata = mem_word(mem_addr);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h88) begin
      bad++;
      $display("FAIL rstfill_pre got req=%b addr=%h exp req=1 addr=00000088", mem_req, mem_addr);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || stall_out !== 1'b0 || instr_valid !== 1'b0 || instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL rstfill_async got req=%b st=%b v=%b pc=%h exp 0 0 0 0", mem_req, stall_out, instr_valid, instr_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_miss("rstfill_after", 32'h80);
    serve_fill(32'h80, 1, 32'h80);
    check_hit("rstfill_refill", 32'h80);
    fetchpc = 32'h88;
    @(negedge clk);
    check_hit("rstfill_beat2", 32'h88);
  endtask

  task automatic test_address_wrap();
    fetchpc = 32'hFFFFFFFC;
    @(negedge clk);
    check_miss("wrap_top_stall", 32'hFFFFFFFC);
    serve_fill(32'hFFFFFFE0, 1, 32'hFFFFFFFC);
    check_hit("wrap_top_hit", 32'hFFFFFFFC);
    fetchpc = 32'h0;
    @(negedge clk);
    check_miss("wrap_zero_stall", 32'h0);
    serve_fill(32'h0, 1, 32'h0);
    check_hit("wrap_zero_hit", 32'h0);
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_sequential_hits();
    test_line_crossing();
    test_slow_memory();
    test_inval_fill();
    test_inval_idle();
    test_reset_mid_fill();
    test_address_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
